// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid storage,
// flush-to-bubble and a saturating bubble-cycle counter. All state changes on the falling edge.
module pipe_stage_buffer #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       PC_W      = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter bit                SKID      = 1'b1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e              state_q, state_d;
  logic                in_ready_q;
  logic [DATA_W-1:0]   head_instr_q, skid_instr_q;
  logic [PC_W-1:0]     head_pc_q, skid_pc_q;
  logic [CNT_W-1:0]    bubble_cnt_q;
  logic                accept, consume;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // State register
  always_ff @(negedge clock) begin
    if (reset) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StTwo);
    end
  end

  // Next-state logic; flush overrides any handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (accept) state_d = StOne;
      StOne: begin
        if (accept && !consume && SKID) state_d = StTwo;
        else if (!accept && consume)    state_d = StEmpty;
      end
      StTwo:   if (consume) state_d = StOne;
      default: state_d = StEmpty;
    endcase
    if (flush) state_d = StEmpty;
  end

  // Output logic
  always_comb begin
    out_valid = (state_q != StEmpty);
    in_ready  = SKID ? in_ready_q : (!out_valid | out_ready);
    out_instr = out_valid ? head_instr_q : NOP_INSTR;
    out_pc    = out_valid ? head_pc_q : '0;
  end

  // Payload storage; an input offered together with flush is dropped
  always_ff @(negedge clock) begin
    if (reset) begin
      head_instr_q <= '0;
      head_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else if (!flush) begin
      if (state_q == StTwo && consume) begin
        head_instr_q <= skid_instr_q;
        head_pc_q    <= skid_pc_q;
      end else if (accept && (state_q == StEmpty || consume)) begin
        head_instr_q <= in_instr;
        head_pc_q    <= in_pc;
      end
      if (SKID && accept && state_q == StOne && !consume) begin
        skid_instr_q <= in_instr;
        skid_pc_q    <= in_pc;
      end
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else if (!out_valid && bubble_cnt_q != {CNT_W{1'b1}}) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;

endmodule
